input_frame_scheduler: RTL and testbench
========================================

Name: input_frame_scheduler

Overview:
- Sequences once-per-frame polling of the controller serial interface and hands a stable input snapshot to the pixel generation / input display datapath.
- Launches a poll at the start of vertical blanking, waits for completion with a timeout, and validates the response into a shadow register.
- Commits the shadow to the outputs only at a fixed blanking line, so displayed inputs never change mid-frame.
- Forces neutral outputs and drops pad_connected after repeated missed polls.

Parameters:
- POLL_LINE, 481, y value at which a poll is launched (x==0).
- COMMIT_LINE, 524, y value at which the shadow is committed to the outputs (x==0). Must be greater than POLL_LINE.
- TIMEOUT_CYCLES, 50000, clk cycles allowed between poll_req rising and poll_ack.
- STALE_FRAMES, 4, consecutive commits without new data before outputs are neutralised.

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high
- x  in  10  VGA controller pixel column
- y  in  10  VGA controller pixel row
- poll_req  out  1  request a controller transaction; held until poll_ack
- poll_ack  in  1  one-cycle pulse: transaction finished, poll_data/poll_error valid this cycle
- poll_error  in  1  transaction failed (no response / bad parity); sampled with poll_ack
- poll_data  in  64  raw 8-byte response; byte0 = [63:56] … byte7 = [7:0]
- pad_buttons  out  12  {start,Y,X,B,A,L,R,Z,D_UP,D_DOWN,D_RIGHT,D_LEFT}
- joy_x, joy_y, c_stick_x, c_stick_y, l_trigger, r_trigger  out  8 each  committed analog values
- pad_connected  out  1  1 while a valid poll has been committed within STALE_FRAMES frames
- poll_err_count  out  8  saturating count of failed/timed-out/invalid polls

Behaviour:
- Reset values:
  - pad_buttons=0, sticks (joy_x, joy_y, c_stick_x, c_stick_y)=8'h80, triggers=0.
  - pad_connected=0, poll_err_count=0, poll_req=0.
  - Internal stale counter = STALE_FRAMES, shadow_new=0, FSM=IDLE.
- poll_tick: x==0 && y==POLL_LINE. commit_tick: x==0 && y==COMMIT_LINE. Both decoded combinationally and acted on at that clock edge.
- FSM states:
  - IDLE: on poll_tick go to REQ, poll_req<=1, timeout counter<=0.
  - REQ: timeout counter increments each cycle.
    - poll_ack with no error and a valid frame -> CAPTURE.
    - poll_ack with error, or an invalid frame -> IDLE, poll_req<=0, err count +1.
    - Counter reaching TIMEOUT_CYCLES-1 without poll_ack -> IDLE, poll_req<=0, err count +1.
  - CAPTURE (1 cycle): load shadow from the registered response, shadow_new<=1, poll_req<=0 -> IDLE.
- poll_req deasserts on the edge after poll_ack is sampled. A late poll_ack arriving in IDLE is ignored.
- Valid frame: byte0[7:5]==3'b000 and byte1[7]==1.
- Field mapping:
  - Byte0 bits[4:0] = start,Y,X,B,A.
  - Byte1 bits[6:0] = L,R,Z,D_UP,D_DOWN,D_RIGHT,D_LEFT.
  - Bytes 2-7 = joy_x, joy_y, c_stick_x, c_stick_y, l_trigger, r_trigger.
- poll_tick while not in IDLE: ignored, no error counted.
- Commit on commit_tick, outputs visible the cycle after the tick:
  - If shadow_new: outputs <= shadow, stale<=0, pad_connected<=1, shadow_new<=0.
  - Else: stale<=min(stale+1, STALE_FRAMES). If the new stale value ==STALE_FRAMES, outputs <= neutral and pad_connected<=0. Otherwise outputs hold.
- CAPTURE coinciding with commit_tick: the commit uses pre-edge shadow_new. The new capture stays pending for the next frame.
- Outputs change only on commit edges or reset; they are stable for the entire visible region.
- poll_err_count saturates at 8'hFF.
- Reset mid-transaction: poll_req drops immediately (async), and all state returns to reset values.

Test Plan:
- Reset, then a full frame with poll_ack 100 cycles after poll_req, poll_data=64'h0180_7F80_8080_0000 (byte0=01 → A=1, byte1=80, joy_x=7F). At line 524: pad_buttons=12'h080, joy_x=8'h7F, pad_connected=1. Outputs unchanged between lines 0-523.
- Never assert poll_ack. poll_req must drop exactly TIMEOUT_CYCLES cycles after rising; poll_err_count=1; outputs hold previous values.
- After one good frame, run 4 frames with poll_error=1. pad_connected stays 1 for 3 commits, then drops at the 4th commit with sticks=8'h80, buttons=0, triggers=0. poll_err_count=4.
- Invalid frame (byte1=8'h00, poll_error=0) -> rejected, error count +1, shadow not loaded, outputs unchanged at commit.
- Assert poll_ack on the cycle where y=COMMIT_LINE, x=0 (with COMMIT_LINE override). The data must appear only at the following frame's commit.
- Assert reset while poll_req=1 -> poll_req=0 the same cycle; all outputs at reset values; next poll_tick issues a fresh poll_req.

Source files
------------

// File: rtl/input_frame_scheduler.sv
// ---------------------------------------------------------------------------
// input_frame_scheduler
//
// Polls the controller once per frame. The poll is launched at the start of
// vertical blanking and the response is validated into a shadow register.
// The shadow is committed to the outputs at one fixed blanking line, so the
// displayed inputs never change in the middle of a frame. If too many frames
// pass without new data, the outputs are forced to neutral and pad_connected
// drops.
//
// Ports:
//   clk, reset          100 MHz clock; asynchronous active-high reset
//   x, y                VGA pixel column / row
//   poll_req            held high from poll launch until the transaction ends
//   poll_ack            one-cycle completion pulse; poll_data and poll_error
//                       are valid in this cycle
//   poll_error          the transaction failed
//   poll_data           raw 8-byte response, byte0 = [63:56]
//   pad_buttons         {start,Y,X,B,A,L,R,Z,D_UP,D_DOWN,D_RIGHT,D_LEFT}
//   joy_x .. r_trigger  committed analog values
//   pad_connected       a valid poll was committed within STALE_FRAMES frames
//   poll_err_count      saturating count of failed, timed-out or invalid polls
// ---------------------------------------------------------------------------
module input_frame_scheduler #(
    parameter int POLL_LINE      = 481,
    parameter int COMMIT_LINE    = 524,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int STALE_FRAMES   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic        poll_req,
    input  logic        poll_ack,
    input  logic        poll_error,
    input  logic [63:0] poll_data,
    output logic [11:0] pad_buttons,
    output logic [7:0]  joy_x,
    output logic [7:0]  joy_y,
    output logic [7:0]  c_stick_x,
    output logic [7:0]  c_stick_y,
    output logic [7:0]  l_trigger,
    output logic [7:0]  r_trigger,
    output logic        pad_connected,
    output logic [7:0]  poll_err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(STALE_FRAMES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    localparam logic [9:0]    POLL_Y    = 10'(POLL_LINE);
    localparam logic [9:0]    COMMIT_Y  = 10'(COMMIT_LINE);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_FRAMES);

    // Decoded pad image: {buttons[11:0], jx, jy, cx, cy, lt, rt}
    localparam logic [59:0] NEUTRAL = {12'h000, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00};

    // A frame is usable only when byte0[7:5] is zero and byte1[7] is set.
    function automatic logic frame_valid(input logic [63:0] d);
        return (d[63:61] == 3'b000) && d[55];
    endfunction

    // Extract the button bits and the six analog bytes from a raw response.
    function automatic logic [59:0] decode(input logic [63:0] d);
        return {d[60:56], d[54:48], d[47:0]};
    endfunction

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          poll_req_q, poll_req_d;
    logic [59:0]   resp_q, resp_d;
    logic [59:0]   shadow_q, shadow_d;
    logic          shadow_new_q, shadow_new_d;
    logic [SW-1:0] stale_q, stale_d;
    logic [59:0]   pad_q, pad_d;
    logic          conn_q, conn_d;
    logic [7:0]    err_q, err_d;
    logic          err_inc_s;
    logic [SW-1:0] stale_next_s;
    logic          poll_tick_s;
    logic          commit_tick_s;

    assign poll_tick_s   = (x == 10'd0) && (y == POLL_Y);
    assign commit_tick_s = (x == 10'd0) && (y == COMMIT_Y);

    // Next-state logic for the poll FSM, the commit path and the error counter.
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        poll_req_d   = poll_req_q;
        resp_d       = resp_q;
        shadow_d     = shadow_q;
        shadow_new_d = shadow_new_q;
        stale_d      = stale_q;
        pad_d        = pad_q;
        conn_d       = conn_q;
        err_inc_s    = 1'b0;
        stale_next_s = (stale_q == STALE_MAX) ? stale_q : stale_q + 1'b1;

        // The commit is evaluated first. A capture on the same edge then
        // re-arms shadow_new, so that data waits for the next frame.
        if (commit_tick_s) begin
            if (shadow_new_q) begin
                pad_d        = shadow_q;
                conn_d       = 1'b1;
                stale_d      = '0;
                shadow_new_d = 1'b0;
            end else begin
                stale_d = stale_next_s;
                if (stale_next_s == STALE_MAX) begin
                    pad_d  = NEUTRAL;
                    conn_d = 1'b0;
                end else begin
                    pad_d  = pad_q;
                    conn_d = conn_q;
                end
            end
        end else begin
            stale_d = stale_q;
        end

        case (state_q)
            S_IDLE: begin
                if (poll_tick_s) begin
                    state_d    = S_REQ;
                    poll_req_d = 1'b1;
                    tmo_d      = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (poll_ack) begin
                    if (!poll_error && frame_valid(poll_data)) begin
                        state_d = S_CAPTURE;
                        resp_d  = decode(poll_data);
                    end else begin
                        state_d    = S_IDLE;
                        poll_req_d = 1'b0;
                        err_inc_s  = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = S_IDLE;
                    poll_req_d = 1'b0;
                    err_inc_s  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                shadow_d     = resp_q;
                shadow_new_d = 1'b1;
                poll_req_d   = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                poll_req_d = 1'b0;
            end
        endcase

        if (err_inc_s && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end else begin
            err_d = err_q;
        end
    end

    // State registers; the asynchronous reset drops poll_req immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            poll_req_q   <= 1'b0;
            resp_q       <= '0;
            shadow_q     <= NEUTRAL;
            shadow_new_q <= 1'b0;
            stale_q      <= STALE_MAX;
            pad_q        <= NEUTRAL;
            conn_q       <= 1'b0;
            err_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            poll_req_q   <= poll_req_d;
            resp_q       <= resp_d;
            shadow_q     <= shadow_d;
            shadow_new_q <= shadow_new_d;
            stale_q      <= stale_d;
            pad_q        <= pad_d;
            conn_q       <= conn_d;
            err_q        <= err_d;
        end
    end

    assign poll_req       = poll_req_q;
    assign pad_buttons    = pad_q[59:48];
    assign joy_x          = pad_q[47:40];
    assign joy_y          = pad_q[39:32];
    assign c_stick_x      = pad_q[31:24];
    assign c_stick_y      = pad_q[23:16];
    assign l_trigger      = pad_q[15:8];
    assign r_trigger      = pad_q[7:0];
    assign pad_connected  = conn_q;
    assign poll_err_count = err_q;

endmodule

// File: tb/tb_input_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_input_frame_scheduler
//
// Drives a shrunken raster (H x V) with reduced poll/commit lines and timeout,
// and emulates the controller's poll_ack/poll_data responses. A table of
// frame scenarios with hand-computed expectations is run first, followed by
// a reset-during-transaction sequence and random frames checked against a
// frame-level reference model.
// ---------------------------------------------------------------------------
module tb_input_frame_scheduler;

    localparam int H   = 32;
    localparam int V   = 20;
    localparam int PL  = 10;
    localparam int CL  = 14;
    localparam int TO  = 200;
    localparam int SF  = 4;
    localparam int GAP = (CL - PL) * H;  // edges from poll launch to commit edge

    localparam logic [63:0] D1  = 64'h0180_7F80_8080_0000;
    localparam logic [63:0] D2  = 64'h1FFF_0102_0304_0506;
    localparam logic [63:0] INV = 64'h0100_5555_5555_5555;
    localparam logic [63:0] D3  = 64'h0A81_C0DE_1234_5678;
    localparam logic [60:0] NEUTRAL_OUT = {12'h000, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 1'b0};

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        poll_req, poll_ack, poll_error;
    logic [63:0] poll_data;
    logic [11:0] pad_buttons;
    logic [7:0]  joy_x, joy_y, c_stick_x, c_stick_y, l_trigger, r_trigger;
    logic        pad_connected;
    logic [7:0]  poll_err_count;

    int n_pass  = 0;
    int n_total = 0;

    input_frame_scheduler #(
        .POLL_LINE(PL), .COMMIT_LINE(CL), .TIMEOUT_CYCLES(TO), .STALE_FRAMES(SF)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .poll_req(poll_req), .poll_ack(poll_ack), .poll_error(poll_error),
        .poll_data(poll_data), .pad_buttons(pad_buttons),
        .joy_x(joy_x), .joy_y(joy_y), .c_stick_x(c_stick_x), .c_stick_y(c_stick_y),
        .l_trigger(l_trigger), .r_trigger(r_trigger),
        .pad_connected(pad_connected), .poll_err_count(poll_err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          delay;   // 0 = never acknowledge
        bit          err;
        logic [63:0] data;
        logic [11:0] exp_buttons;
        logic [7:0]  exp_joy_x;
        bit          exp_conn;
        logic [7:0]  exp_errs;
    } vec_t;

    vec_t tbl [10];

    // Frame-level reference model state
    logic [60:0] m_out;
    int          m_stale;
    bit          m_pend;
    logic [59:0] m_pdata;
    int          m_err;

    // Per-frame observations
    int req_len;
    bit saw_req;
    bit stable_ok;

    function automatic logic [60:0] dut_outs();
        return {pad_buttons, joy_x, joy_y, c_stick_x, c_stick_y, l_trigger, r_trigger, pad_connected};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_out   = NEUTRAL_OUT;
        m_stale = SF;
        m_pend  = 1'b0;
        m_pdata = '0;
        m_err   = 0;
    endtask

    // One frame at transaction level: was the poll good, and did its data
    // land before or after this frame's commit?
    task automatic model_frame(input int delay, input bit err, input logic [63:0] data);
        logic [7:0] b0, b1;
        bit good;
        b0   = data[63:56];
        b1   = data[55:48];
        good = (delay > 0) && (delay < TO) && !err && (b0[7:5] == 3'b000) && b1[7];
        if (!good) m_err = (m_err < 255) ? m_err + 1 : 255;
        if (good && delay < GAP) begin
            m_pend  = 1'b1;
            m_pdata = {b0[4:0], b1[6:0], data[47:0]};
        end
        if (m_pend) begin
            m_out   = {m_pdata, 1'b1};
            m_stale = 0;
            m_pend  = 1'b0;
        end else begin
            m_stale = (m_stale + 1 > SF) ? SF : m_stale + 1;
            if (m_stale == SF) m_out = NEUTRAL_OUT;
        end
        if (good && delay >= GAP) begin
            m_pend  = 1'b1;
            m_pdata = {b0[4:0], b1[6:0], data[47:0]};
        end
    endtask

    // Run one full raster frame, answering the poll after 'delay' edges.
    task automatic run_frame(input int delay, input bit err, input logic [63:0] data, input bit stray);
        int cyc, rise;
        bit prev;
        logic [60:0] snap;
        cyc = 0; rise = -1; prev = poll_req;
        req_len = -1; saw_req = 1'b0; stable_ok = 1'b1;
        snap = dut_outs();
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                x          = 10'(xx);
                y          = 10'(yy);
                poll_error = err;
                poll_data  = data;
                poll_ack   = (stray && yy == 2 && xx == 5) ||
                             (rise >= 0 && req_len < 0 && delay > 0 && (cyc - rise) == delay - 1);
                @(posedge clk);
                #1;
                cyc++;
                if (poll_req && !prev) begin
                    rise    = cyc;
                    saw_req = 1'b1;
                end
                if (!poll_req && prev && rise >= 0 && req_len < 0) req_len = cyc - rise;
                prev = poll_req;
                if (xx == 0 && yy == CL) snap = dut_outs();
                else if (dut_outs() !== snap) stable_ok = 1'b0;
            end
        end
        poll_ack = 1'b0;
    endtask

    initial begin
        // Hand-computed frame scenarios, applied in order after reset.
        tbl[0] = '{100,     1'b0, D1,  12'h080, 8'h7F, 1'b1, 8'd0};
        tbl[1] = '{50,      1'b1, D1,  12'h080, 8'h7F, 1'b1, 8'd1};
        tbl[2] = '{50,      1'b1, D1,  12'h080, 8'h7F, 1'b1, 8'd2};
        tbl[3] = '{50,      1'b1, D1,  12'h080, 8'h7F, 1'b1, 8'd3};
        tbl[4] = '{50,      1'b1, D1,  12'h000, 8'h80, 1'b0, 8'd4};
        tbl[5] = '{100,     1'b0, D2,  12'hFFF, 8'h01, 1'b1, 8'd4};
        tbl[6] = '{0,       1'b0, D2,  12'hFFF, 8'h01, 1'b1, 8'd5};
        tbl[7] = '{60,      1'b0, INV, 12'hFFF, 8'h01, 1'b1, 8'd6};
        tbl[8] = '{GAP,     1'b0, D3,  12'hFFF, 8'h01, 1'b1, 8'd6};
        tbl[9] = '{50,      1'b1, D1,  12'h501, 8'hC0, 1'b1, 8'd7};

        reset = 1'b1; x = 10'd1; y = 10'd0;
        poll_ack = 1'b0; poll_error = 1'b0; poll_data = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_outs", dut_outs(), NEUTRAL_OUT);
        check("reset_errs", poll_err_count, 8'd0);
        check("reset_req", poll_req, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_frame(tbl[i].delay, tbl[i].err, tbl[i].data, 1'b0);
            model_frame(tbl[i].delay, tbl[i].err, tbl[i].data);
            check($sformatf("tbl%0d_buttons", i), pad_buttons, tbl[i].exp_buttons);
            check($sformatf("tbl%0d_joy_x", i), joy_x, tbl[i].exp_joy_x);
            check($sformatf("tbl%0d_conn", i), pad_connected, tbl[i].exp_conn);
            check($sformatf("tbl%0d_errs", i), poll_err_count, tbl[i].exp_errs);
            check($sformatf("tbl%0d_stable", i), stable_ok, 1'b1);
            if (tbl[i].delay == 0) check($sformatf("tbl%0d_timeout_len", i), req_len, TO);
        end

        // Reset while a poll is outstanding.
        x = 10'd0; y = 10'(PL);
        @(posedge clk);
        #1;
        x = 10'd1;
        check("rst_req_rose", poll_req, 1'b1);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_req_async", poll_req, 1'b0);
        check("rst_outs", dut_outs(), NEUTRAL_OUT);
        check("rst_errs", poll_err_count, 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        y = 10'd0;
        model_reset();
        run_frame(100, 1'b0, D1, 1'b1);
        model_frame(100, 1'b0, D1);
        check("rst_fresh_req", saw_req, 1'b1);
        check("rst_frame_outs", dut_outs(), m_out);

        // Random frames against the reference model.
        for (int f = 0; f < 40; f++) begin
            int          sel, dly;
            bit          er, stray;
            logic [63:0] d;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      dly = 0;
            else if (sel < 7)  dly = int'($urandom_range(1, GAP - 10));
            else               dly = int'($urandom_range(GAP + 2, TO - 5));
            er    = ($urandom_range(0, 3) == 0);
            stray = ($urandom_range(0, 3) == 0);
            d     = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                d[63:61] = 3'b000;
                d[55]    = 1'b1;
            end
            run_frame(dly, er, d, stray);
            model_frame(dly, er, d);
            check($sformatf("rnd%0d_outs", f), dut_outs(), m_out);
            check($sformatf("rnd%0d_errs", f), poll_err_count, 8'(m_err));
            check($sformatf("rnd%0d_stable", f), stable_ok, 1'b1);
            if (dly == 0) check($sformatf("rnd%0d_timeout_len", f), req_len, TO);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
